// File: rtl/time_chain_pkg.sv
// Shared constants for the HH:MM:SS counter-chain sequencer: digit indices, digit limits, mode codes.
package time_chain_pkg;

    localparam int unsigned NUM_DIGITS = 6;

    localparam int unsigned IDX_SECU = 0;
    localparam int unsigned IDX_SECT = 1;
    localparam int unsigned IDX_MINU = 2;
    localparam int unsigned IDX_MINT = 3;
    localparam int unsigned IDX_HRU  = 4;
    localparam int unsigned IDX_HRT  = 5;

    localparam int unsigned SEC_TENS_MAX = 5;
    localparam int unsigned UNITS_MAX    = 9;
    localparam int unsigned HR_TENS_TOP  = 2;
    localparam int unsigned HR_UNITS_TOP = 3;

    localparam int unsigned BUSY_W      = 2;
    localparam int unsigned BUSY_CYCLES = 2;

    localparam logic [1:0] MODE_RUN     = 2'b00;
    localparam logic [1:0] MODE_SET_HR  = 2'b01;
    localparam logic [1:0] MODE_SET_MIN = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN     = MODE_RUN,
        ST_SET_HR  = MODE_SET_HR,
        ST_SET_MIN = MODE_SET_MIN
    } mode_e;

endpackage

// File: rtl/tc_carry_calc.sv
// Combinational strobe vectors for a run tick, an hour increment and a minute increment.
module tc_carry_calc
    import time_chain_pkg::*;
(
    input  logic [3:0]            SecU,
    input  logic [2:0]            SecT,
    input  logic [3:0]            MinU,
    input  logic [2:0]            MinT,
    input  logic [3:0]            HrU,
    input  logic [1:0]            HrT,
    output logic [NUM_DIGITS-1:0] run_en_c,
    output logic [NUM_DIGITS-1:0] run_ld_c,
    output logic [NUM_DIGITS-1:0] hr_en_c,
    output logic [NUM_DIGITS-1:0] hr_ld_c,
    output logic [NUM_DIGITS-1:0] min_en_c
);

    logic sec_u_last;
    logic sec_t_last;
    logic min_u_last;
    logic min_t_last;
    logic hr_u_last;
    logic hr_day_end;

    // Digits are widened to the constant width so no digit bit is ever dropped.
    assign sec_u_last = (32'(SecU) == UNITS_MAX);
    assign sec_t_last = (32'(SecT) == SEC_TENS_MAX);
    assign min_u_last = (32'(MinU) == UNITS_MAX);
    assign min_t_last = (32'(MinT) == SEC_TENS_MAX);
    assign hr_u_last  = (32'(HrU) == UNITS_MAX);
    assign hr_day_end = (32'(HrT) == HR_TENS_TOP) && (32'(HrU) == HR_UNITS_TOP);

    always_comb begin
        run_en_c = '0;
        run_ld_c = '0;
        hr_en_c  = '0;
        hr_ld_c  = '0;
        min_en_c = '0;

        // Ripple carry for a one-second tick, with the 23:59:59 wrap as clear.
        run_en_c[IDX_SECU] = 1'b1;
        run_en_c[IDX_SECT] = sec_u_last;
        run_en_c[IDX_MINU] = run_en_c[IDX_SECT] & sec_t_last;
        run_en_c[IDX_MINT] = run_en_c[IDX_MINU] & min_u_last;
        run_en_c[IDX_HRU]  = run_en_c[IDX_MINT] & min_t_last;
        run_en_c[IDX_HRT]  = run_en_c[IDX_HRU] & (hr_u_last | hr_day_end);
        run_ld_c[IDX_HRU]  = run_en_c[IDX_HRU] & hr_day_end;
        run_ld_c[IDX_HRT]  = run_en_c[IDX_HRU] & hr_day_end;

        hr_en_c[IDX_HRU] = 1'b1;
        hr_en_c[IDX_HRT] = hr_day_end | hr_u_last;
        hr_ld_c[IDX_HRU] = hr_day_end;
        hr_ld_c[IDX_HRT] = hr_day_end;

        min_en_c[IDX_MINU] = 1'b1;
        min_en_c[IDX_MINT] = min_u_last;
    end

endmodule

// File: rtl/time_chain_ctrl.sv
// Mode FSM and registered Enable/LD strobe generation for the alarm-clock digit chain.
module time_chain_ctrl
    import time_chain_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Clr,
    input  logic                  Tick1Hz,
    input  logic                  BtnMode,
    input  logic                  BtnInc,
    input  logic [3:0]            SecU,
    input  logic [2:0]            SecT,
    input  logic [3:0]            MinU,
    input  logic [2:0]            MinT,
    input  logic [3:0]            HrU,
    input  logic [1:0]            HrT,
    output logic [NUM_DIGITS-1:0] EN,
    output logic [NUM_DIGITS-1:0] LD,
    output logic [1:0]            Mode,
    output logic                  Blink,
    output logic                  Busy
);

    mode_e                  state_q, state_d;
    logic [NUM_DIGITS-1:0]  en_d, ld_d;
    logic                   blink_d;
    logic [BUSY_W-1:0]      busy_cnt_q, busy_cnt_d;
    logic                   tick_ok;
    logic                   inc_ok;
    logic [NUM_DIGITS-1:0]  run_en_c, run_ld_c, hr_en_c, hr_ld_c, min_en_c;

    tc_carry_calc u_carry (
        .SecU     (SecU),
        .SecT     (SecT),
        .MinU     (MinU),
        .MinT     (MinT),
        .HrU      (HrU),
        .HrT      (HrT),
        .run_en_c (run_en_c),
        .run_ld_c (run_ld_c),
        .hr_en_c  (hr_en_c),
        .hr_ld_c  (hr_ld_c),
        .min_en_c (min_en_c)
    );

    // Tick and increment are ignored while the chain settles; a mode press swallows an increment.
    assign tick_ok = Tick1Hz & ~Busy;
    assign inc_ok  = BtnInc & ~Busy & ~BtnMode;
    assign Mode    = 2'(state_q);

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q    <= ST_RUN;
            EN         <= '0;
            LD         <= '0;
            Blink      <= 1'b0;
            Busy       <= 1'b0;
            busy_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            EN         <= en_d;
            LD         <= ld_d;
            Blink      <= blink_d;
            Busy       <= (busy_cnt_d != '0);
            busy_cnt_q <= busy_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        en_d       = '0;
        ld_d       = '0;
        blink_d    = Blink;
        busy_cnt_d = (busy_cnt_q == '0) ? '0 : busy_cnt_q - BUSY_W'(1);

        unique case (state_q)
            ST_RUN: begin
                if (tick_ok) begin
                    en_d       = run_en_c;
                    ld_d       = run_ld_c;
                    busy_cnt_d = BUSY_W'(BUSY_CYCLES);
                end
                if (BtnMode) state_d = ST_SET_HR;
            end
            ST_SET_HR: begin
                if (tick_ok) blink_d = ~Blink;
                if (inc_ok) begin
                    en_d       = hr_en_c;
                    ld_d       = hr_ld_c;
                    busy_cnt_d = BUSY_W'(BUSY_CYCLES);
                end
                if (BtnMode) state_d = ST_SET_MIN;
            end
            ST_SET_MIN: begin
                if (tick_ok) blink_d = ~Blink;
                if (inc_ok) begin
                    en_d       = min_en_c;
                    busy_cnt_d = BUSY_W'(BUSY_CYCLES);
                end
                // Leaving time-set clears seconds so the clock restarts on a whole minute.
                if (BtnMode) begin
                    state_d              = ST_RUN;
                    en_d                 = '0;
                    ld_d                 = '0;
                    en_d[IDX_SECU]       = 1'b1;
                    en_d[IDX_SECT]       = 1'b1;
                    ld_d[IDX_SECU]       = 1'b1;
                    ld_d[IDX_SECT]       = 1'b1;
                    blink_d              = 1'b0;
                    busy_cnt_d           = BUSY_W'(BUSY_CYCLES);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

endmodule

// File: tb/tb_time_chain_ctrl.sv
// Directed self-checking bench for time_chain_ctrl with hand-computed strobe vectors.
module tb_time_chain_ctrl;

    logic       Clk = 1'b0;
    logic       Clr;
    logic       Tick1Hz, BtnMode, BtnInc;
    logic [3:0] SecU, MinU, HrU;
    logic [2:0] SecT, MinT;
    logic [1:0] HrT;
    logic [5:0] EN, LD;
    logic [1:0] Mode;
    logic       Blink, Busy;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    time_chain_ctrl dut (
        .Clk(Clk), .Clr(Clr), .Tick1Hz(Tick1Hz), .BtnMode(BtnMode), .BtnInc(BtnInc),
        .SecU(SecU), .SecT(SecT), .MinU(MinU), .MinT(MinT), .HrU(HrU), .HrT(HrT),
        .EN(EN), .LD(LD), .Mode(Mode), .Blink(Blink), .Busy(Busy)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse(input logic t, input logic m, input logic i);
        Tick1Hz = t; BtnMode = m; BtnInc = i;
        step();
        Tick1Hz = 1'b0; BtnMode = 1'b0; BtnInc = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        HrT = 2'(h / 10); HrU = 4'(h % 10);
        MinT = 3'(m / 10); MinU = 4'(m % 10);
        SecT = 3'(s / 10); SecU = 4'(s % 10);
    endtask

    // Counter model: enabled digit clears on LD, else counts up and wraps after its last value.
    function automatic int next_digit(input int d, input int last, input logic en, input logic ld);
        if (!en) return d;
        if (ld) return 0;
        return (d == last) ? 0 : d + 1;
    endfunction

    task automatic test_reset();
        Clr = 1'b0;
        step(); step();
        checks++; if (EN !== 6'b0)  begin errors++; $display("FAIL reset_en: got %b want 000000", EN); end
        checks++; if (LD !== 6'b0)  begin errors++; $display("FAIL reset_ld: got %b want 000000", LD); end
        checks++; if (Mode !== 2'b00) begin errors++; $display("FAIL reset_mode: got %b want 00", Mode); end
        checks++; if (Blink !== 1'b0) begin errors++; $display("FAIL reset_blink: got %b want 0", Blink); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        Clr = 1'b1;
        step();
    endtask

    task automatic test_clr_mid_strobe();
        logic seen;
        set_time(12, 0, 0);
        pulse(1'b1, 1'b1, 1'b0);
        checks++; if (EN !== 6'b000001) begin errors++; $display("FAIL clr_pre_en: got %b want 000001", EN); end
        checks++; if (Mode !== 2'b01) begin errors++; $display("FAIL clr_pre_mode: got %b want 01", Mode); end
        Clr = 1'b0;
        #1;
        checks++; if (EN !== 6'b0) begin errors++; $display("FAIL clr_en: got %b want 000000", EN); end
        checks++; if (LD !== 6'b0) begin errors++; $display("FAIL clr_ld: got %b want 000000", LD); end
        checks++; if (Mode !== 2'b00) begin errors++; $display("FAIL clr_mode: got %b want 00", Mode); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b want 0", Busy); end
        step();
        Clr = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (EN !== 6'b0 || LD !== 6'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL clr_after_release: got pulse=%b want 0", seen); end
    endtask

    task automatic test_carry();
        set_time(12, 59, 59);
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (EN !== 6'b011111) begin errors++; $display("FAIL carry_en: got %b want 011111", EN); end
        checks++; if (LD !== 6'b0) begin errors++; $display("FAIL carry_ld: got %b want 000000", LD); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL carry_busy1: got %b want 1", Busy); end
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (EN !== 6'b0) begin errors++; $display("FAIL busy_tick_dropped: got %b want 000000", EN); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL carry_busy2: got %b want 1", Busy); end
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (EN !== 6'b0) begin errors++; $display("FAIL busy_tick_dropped2: got %b want 000000", EN); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL carry_busy_end: got %b want 0", Busy); end
    endtask

    task automatic test_rollover();
        int su, st, mu, mt, hu, ht;
        set_time(23, 59, 59);
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (EN !== 6'b111111) begin errors++; $display("FAIL roll_en: got %b want 111111", EN); end
        checks++; if (LD !== 6'b110000) begin errors++; $display("FAIL roll_ld: got %b want 110000", LD); end
        su = next_digit(int'(SecU), 9, EN[0], LD[0]);
        st = next_digit(int'(SecT), 5, EN[1], LD[1]);
        mu = next_digit(int'(MinU), 9, EN[2], LD[2]);
        mt = next_digit(int'(MinT), 5, EN[3], LD[3]);
        hu = next_digit(int'(HrU), 9, EN[4], LD[4]);
        ht = next_digit(int'(HrT), 2, EN[5], LD[5]);
        checks++;
        if (ht * 100000 + hu * 10000 + mt * 1000 + mu * 100 + st * 10 + su != 0) begin
            errors++; $display("FAIL roll_counters: got %0d%0d:%0d%0d:%0d%0d want 00:00:00", ht, hu, mt, mu, st, su);
        end
        set_time(0, 0, 0);
        step(); step();
    endtask

    task automatic test_set_hr();
        pulse(1'b0, 1'b1, 1'b0);
        checks++; if (Mode !== 2'b01) begin errors++; $display("FAIL sethr_mode: got %b want 01", Mode); end
        checks++; if (EN !== 6'b0) begin errors++; $display("FAIL sethr_entry_en: got %b want 000000", EN); end
        set_time(23, 15, 42);
        pulse(1'b0, 1'b0, 1'b1);
        checks++; if (EN !== 6'b110000) begin errors++; $display("FAIL sethr_23_en: got %b want 110000", EN); end
        checks++; if (LD !== 6'b110000) begin errors++; $display("FAIL sethr_23_ld: got %b want 110000", LD); end
        step(); step();
        set_time(9, 15, 42);
        pulse(1'b0, 1'b0, 1'b1);
        checks++; if (EN !== 6'b110000) begin errors++; $display("FAIL sethr_09_en: got %b want 110000", EN); end
        checks++; if (LD !== 6'b0) begin errors++; $display("FAIL sethr_09_ld: got %b want 000000", LD); end
        step(); step();
        set_time(14, 15, 42);
        pulse(1'b0, 1'b0, 1'b1);
        checks++; if (EN !== 6'b010000) begin errors++; $display("FAIL sethr_14_en: got %b want 010000", EN); end
        checks++; if (LD !== 6'b0) begin errors++; $display("FAIL sethr_14_ld: got %b want 000000", LD); end
        step(); step();
        pulse(1'b0, 1'b1, 1'b1);
        checks++; if (Mode !== 2'b10) begin errors++; $display("FAIL mode_inc_mode: got %b want 10", Mode); end
        checks++; if (EN !== 6'b0) begin errors++; $display("FAIL mode_inc_en: got %b want 000000", EN); end
    endtask

    task automatic test_set_min();
        set_time(12, 59, 30);
        pulse(1'b0, 1'b0, 1'b1);
        checks++; if (EN !== 6'b001100) begin errors++; $display("FAIL setmin_59_en: got %b want 001100", EN); end
        checks++; if (LD !== 6'b0) begin errors++; $display("FAIL setmin_59_ld: got %b want 000000", LD); end
        step(); step();
        set_time(12, 0, 30);
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (EN !== 6'b0) begin errors++; $display("FAIL setmin_tick_en: got %b want 000000", EN); end
        checks++; if (Blink !== 1'b1) begin errors++; $display("FAIL setmin_blink: got %b want 1", Blink); end
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (Blink !== 1'b0) begin errors++; $display("FAIL setmin_blink2: got %b want 0", Blink); end
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (Blink !== 1'b1) begin errors++; $display("FAIL setmin_blink3: got %b want 1", Blink); end
    endtask

    task automatic test_run_entry();
        set_time(10, 0, 0);
        pulse(1'b0, 1'b1, 1'b0);
        checks++; if (Mode !== 2'b00) begin errors++; $display("FAIL run_entry_mode: got %b want 00", Mode); end
        checks++; if (EN !== 6'b000011) begin errors++; $display("FAIL run_entry_en: got %b want 000011", EN); end
        checks++; if (LD !== 6'b000011) begin errors++; $display("FAIL run_entry_ld: got %b want 000011", LD); end
        checks++; if (Blink !== 1'b0) begin errors++; $display("FAIL run_entry_blink: got %b want 0", Blink); end
        step(); step();
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (EN !== 6'b000001) begin errors++; $display("FAIL run_tick_en: got %b want 000001", EN); end
        checks++; if (LD !== 6'b0) begin errors++; $display("FAIL run_tick_ld: got %b want 000000", LD); end
    endtask

    initial begin
        Clr = 1'b0; Tick1Hz = 1'b0; BtnMode = 1'b0; BtnInc = 1'b0;
        set_time(0, 0, 0);
        test_reset();
        test_clr_mid_strobe();
        test_carry();
        test_rollover();
        test_set_hr();
        test_set_min();
        test_run_entry();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
